// File: rtl/tdm_demux_deser.sv
// Receive-side TDM deserializer: steps the mux select across WIDTH slots, samples
// one serial bit per slot and publishes the rebuilt parallel word with a 1-cycle pulse.
module tdm_demux_deser #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             din,
  input  logic             din_valid,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             busy,
  output logic             restart_err
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

  state_t             state_r;
  logic [SEL_W-1:0]   sel_r;
  logic [WIDTH-1:0]   shadow_r;
  logic [WIDTH-1:0]   word_r;
  logic               word_valid_r;
  logic               busy_r;
  logic               restart_err_r;

  // Frame sequencer: abort beats start, start beats capture, so a restart on the
  // last slot drops the word instead of publishing it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      sel_r         <= {SEL_W{1'b0}};
      shadow_r      <= {WIDTH{1'b0}};
      word_r        <= {WIDTH{1'b0}};
      word_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      restart_err_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      if (abort) begin
        state_r  <= ST_IDLE;
        sel_r    <= {SEL_W{1'b0}};
        shadow_r <= {WIDTH{1'b0}};
        busy_r   <= 1'b0;
      end else if (start) begin
        restart_err_r <= (state_r == ST_COLLECT);
        state_r       <= ST_COLLECT;
        sel_r         <= {SEL_W{1'b0}};
        shadow_r      <= {WIDTH{1'b0}};
        busy_r        <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            sel_r  <= {SEL_W{1'b0}};
            busy_r <= 1'b0;
          end
          ST_COLLECT: begin
            busy_r <= 1'b1;
            if (din_valid) begin
              shadow_r[sel_r] <= din;
              if (sel_r == SEL_LAST) begin
                // The last bit goes straight into the word, bypassing the shadow.
                word_r       <= {din, shadow_r[WIDTH-2:0]};
                word_valid_r <= 1'b1;
                sel_r        <= {SEL_W{1'b0}};
                if (continuous) begin
                  state_r <= ST_COLLECT;
                  busy_r  <= 1'b1;
                end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              end else begin
                sel_r <= sel_r + SEL_ONE;
              end
            end else begin
              sel_r <= sel_r;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            sel_r   <= {SEL_W{1'b0}};
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel         = sel_r;
  assign word        = word_r;
  assign word_valid  = word_valid_r;
  assign busy        = busy_r;
  assign restart_err = restart_err_r;

endmodule

// File: tb/tb_tdm_demux_deser.sv
// Scoreboard bench for tdm_demux_deser: a loopback mux feeds din from a pattern
// register; expected words are queued at stimulus time and checked by a monitor.
module tb_tdm_demux_deser;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             continuous;
  logic             abort;
  logic             din;
  logic             din_valid;
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             busy;
  logic             restart_err;
  logic [WIDTH-1:0] pat;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] exp_q[$];
  time              pulse_t[$];
  time              t_start;
  time              t_a;
  time              t_b;
  logic [WIDTH-1:0] exp_w;

  tdm_demux_deser #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .din(din), .din_valid(din_valid), .sel(sel), .word(word), .word_valid(word_valid),
    .busy(busy), .restart_err(restart_err)
  );

  // Loopback mux: din is the pattern bit selected by the DUT.
  assign din = pat[sel];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    t_start = $time;
    tick(1);
    start = 1'b0;
  endtask

  task automatic get_pulse(input string name, output time t);
    if (pulse_t.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no word_valid pulse expected one", name);
      t = 0;
    end else begin
      t = pulse_t.pop_front();
    end
  endtask

  // Monitor: every word_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && word_valid) begin
      pulse_t.push_back($time);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word_valid: got word %0h expected no pulse at %0t", word, $time);
      end else begin
        exp_w = exp_q.pop_front();
        chk("word", word, exp_w);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; din_valid = 1'b1;
    pat = 8'h00;
    #2;
    chk("rst_word", word, 8'h00);
    chk("rst_sel", sel, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", restart_err, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // 1: single frame 0xAA
    pat = 8'b10101010;
    exp_q.push_back(8'hAA);
    pulse_t.delete();
    pulse_start();
    chk("c1_busy_start", busy, 1'b1);
    chk("c1_sel0", sel, 3'd0);
    tick(7);
    chk("c1_sel7", sel, 3'd7);
    tick(1);
    chk("c1_valid", word_valid, 1'b1);
    chk("c1_busy_end", busy, 1'b0);
    chk("c1_sel_end", sel, 3'd0);
    tick(1);
    chk("c1_valid_once", word_valid, 1'b0);
    get_pulse("c1_pulse", t_a);
    chk("c1_latency", 32'(t_a - t_start), 32'd90);

    // 2: continuous, two frames of 0xF0 with no gap
    pat = 8'b11110000;
    continuous = 1'b1;
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'hF0);
    pulse_t.delete();
    pulse_start();
    tick(8);
    chk("c2_busy_wrap", busy, 1'b1);
    chk("c2_sel_wrap", sel, 3'd0);
    continuous = 1'b0;
    tick(8);
    chk("c2_busy_end", busy, 1'b0);
    tick(1);
    get_pulse("c2_pulse_a", t_a);
    get_pulse("c2_pulse_b", t_b);
    chk("c2_spacing", 32'(t_b - t_a), 32'd80);

    // 3: stall 3 cycles at sel=4
    pat = 8'hA5;
    exp_q.push_back(8'hA5);
    pulse_t.delete();
    pulse_start();
    tick(4);
    chk("c3_sel4", sel, 3'd4);
    din_valid = 1'b0;
    tick(3);
    chk("c3_sel_hold", sel, 3'd4);
    chk("c3_busy_hold", busy, 1'b1);
    din_valid = 1'b1;
    tick(5);
    get_pulse("c3_pulse", t_a);
    chk("c3_latency", 32'(t_a - t_start), 32'd120);

    // 4: abort at sel=5, then a clean frame
    pat = 8'h3C;
    pulse_start();
    tick(5);
    chk("c4_sel5", sel, 3'd5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("c4_sel_abort", sel, 3'd0);
    chk("c4_busy_abort", busy, 1'b0);
    chk("c4_word_kept", word, 8'hA5);
    tick(10);
    chk("c4_idle_sel", sel, 3'd0);
    exp_q.push_back(8'h3C);
    pulse_start();
    tick(9);
    chk("c4_busy_end", busy, 1'b0);

    // 5: start at sel=3 sets restart_err; frame then completes
    pat = 8'h5A;
    exp_q.push_back(8'h5A);
    pulse_start();
    tick(3);
    chk("c5_sel3", sel, 3'd3);
    pulse_start();
    chk("c5_err", restart_err, 1'b1);
    chk("c5_sel_restart", sel, 3'd0);
    tick(9);
    chk("c5_err_sticky", restart_err, 1'b1);
    chk("c5_word", word, 8'h5A);
    pat = 8'h81;
    exp_q.push_back(8'h81);
    pulse_start();
    chk("c5_err_clear", restart_err, 1'b0);
    tick(9);

    // start on the last slot: restart wins, word not published
    pat = 8'hC3;
    exp_q.push_back(8'hC3);
    pulse_start();
    tick(7);
    chk("c5b_sel7", sel, 3'd7);
    pulse_start();
    chk("c5b_no_valid", word_valid, 1'b0);
    chk("c5b_sel0", sel, 3'd0);
    chk("c5b_word_kept", word, 8'h81);
    tick(9);

    // 6: asynchronous reset mid-frame
    pat = 8'hFF;
    pulse_start();
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    chk("c6_word", word, 8'h00);
    chk("c6_sel", sel, 3'd0);
    chk("c6_valid", word_valid, 1'b0);
    chk("c6_busy", busy, 1'b0);
    chk("c6_err", restart_err, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(10);
    chk("c6_needs_start", busy, 1'b0);
    chk("c6_sel_idle", sel, 3'd0);

    tick(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
